fifo_row_reader: RTL and testbench
==================================

Name: fifo_row_reader

Overview:
Read-side controller for the FIFO unit. It pops FIFO_WIDTH words from a FIFO through its next_en/empty/data_out interface and packs LANES consecutive words into one wide row. Rows are presented on a valid/ready stream, for example to feed a systolic-array input row. Each run is a burst of num_rows rows, started by a start pulse and ended by a one-cycle done pulse.

Parameters:
FIFO_WIDTH, 8, width of one FIFO word.
LANES, 4, words packed per output row (>=2).
ROW_CNT_WIDTH, 16, width of num_rows and the internal rows-left counter.

Ports:
clk  input  1  clock.
rst  input  1  reset.
start  input  1  one-cycle pulse; begins a burst; sampled only in IDLE.
num_rows  input  ROW_CNT_WIDTH  rows in the burst; sampled with start.
fifo_data_in  input  FIFO_WIDTH  FIFO head word (FIFO data_out), valid while fifo_empty=0.
fifo_empty  input  1  FIFO empty flag.
fifo_next_en  output  1  pop strobe to FIFO next_en; combinational.
out_data  output  LANES*FIFO_WIDTH  packed row; lane 0 (first popped word) in bits [FIFO_WIDTH-1:0].
out_valid  output  1  out_data holds an unaccepted row.
out_ready  input  1  consumer accepts row when out_valid && out_ready.
busy  output  1  high in RUN or DRAIN.
done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high. All registers are cleared: state=IDLE, lane_cnt=0, rows_left=0, assembly register=0, out_data=0, out_valid=0, done=0. Therefore busy=0 and fifo_next_en=0 in reset.
- Reset mid-burst aborts the burst. No done pulse; the held row is discarded.
- FSM states (enum): IDLE, RUN, DRAIN.
  - IDLE -> RUN on start with num_rows!=0; rows_left<=num_rows, lane_cnt<=0.
  - IDLE, start with num_rows==0: stay IDLE; done=1 next cycle.
  - RUN -> DRAIN when a pop completes a row (lane_cnt==LANES-1) and rows_left==1.
  - DRAIN -> IDLE when out_valid && out_ready; done=1 in the following cycle (registered pulse).
  - start is ignored outside IDLE.
- Pop rule: fifo_next_en = (state==RUN) && !fifo_empty && !stall.
  - stall = (lane_cnt==LANES-1) && out_valid && !out_ready.
  - Never pop in IDLE/DRAIN; never pop when empty.
- On a pop, fifo_data_in is written into lane lane_cnt of the assembly register.
  - If lane_cnt<LANES-1: lane_cnt++.
  - Else: out_data <= {fifo_data_in, assembled lanes LANES-2..0}, out_valid<=1, lane_cnt<=0, rows_left--.
- out_valid clears on out_valid && out_ready, unless a new row completes in the same cycle, in which case it stays 1 with the new data.
- out_data is stable while out_valid && !out_ready (no overwrite).
- Latency: the pop of a row's last word at edge N gives out_valid=1 after edge N.
- Throughput: with the FIFO never empty and out_ready held at 1, one row per LANES cycles with no bubbles.
- Partial rows are held across FIFO-empty gaps indefinitely; lanes already filled are not lost.
- rows_left arithmetic: unsigned, ROW_CNT_WIDTH; never decremented below 1 in RUN.

Decomposition:
- Shared package tpu_pkg gets the typedef row_reader_state_t {IDLE, RUN, DRAIN} and a localparam for the row width (LANES*FIFO_WIDTH), shared with consumers.
- One natural sub-module, row_assembler: lane counter, assembly register and output register with the valid/ready hold. The FSM and the pop gating stay in the top level.

Test Plan:
- Preload FIFO with 0x01..0x08; LANES=4; start, num_rows=2; out_ready=1 -> rows 0x04030201 and 0x08070605; first out_valid 5 cycles after start; done one cycle after 2nd acceptance; fifo_next_en high for exactly 8 cycles.
- Same preload, out_ready=0 for 10 cycles after first row -> exactly 7 pops; out_data holds 0x04030201; no 8th pop until out_ready rises; 2nd row follows.
- FIFO empty for 5 cycles after word 2 of a row -> fifo_next_en=0 throughout the gap; row completes correctly once words 3–4 are written.
- start with num_rows=0 -> done pulses for one cycle; busy stays 0; no pops.
- Assert rst asynchronously mid-row (lane_cnt=2, out_valid=1) -> out_valid, busy and fifo_next_en drop immediately; no done; next burst starts from lane 0.
- start pulsed during RUN with a different num_rows -> ignored; original row count honoured.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: row-reader FSM encoding and the default packed row
// width seen by consumers of the row stream.
package tpu_pkg;

  localparam int ROW_FIFO_WIDTH = 8;
  localparam int ROW_LANES      = 4;
  localparam int ROW_WIDTH      = ROW_LANES * ROW_FIFO_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } row_reader_state_t;

endpackage

// File: rtl/fifo_row_reader_if.sv
// FIFO read port plus the valid/ready row stream of the row reader.
// master = the reader, slave = FIFO and row consumer side.
interface fifo_row_reader_if #(
  parameter int FIFO_WIDTH = 8,
  parameter int LANES      = 4
);

  logic [FIFO_WIDTH-1:0]       fifo_data_in;
  logic                        fifo_empty;
  logic                        fifo_next_en;
  logic [LANES*FIFO_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    input  fifo_data_in, fifo_empty, out_ready,
    output fifo_next_en, out_data, out_valid
  );

  modport slave (
    output fifo_data_in, fifo_empty, out_ready,
    input  fifo_next_en, out_data, out_valid
  );

endinterface

// File: rtl/fifo_row_reader_row_assembler.sv
// Lane counter, assembly register and output row register. Popped words fill
// lanes 0..LANES-2; the word that lands in the last lane goes straight into
// the output register together with the assembled lanes.
module row_assembler #(
  parameter int FIFO_WIDTH = 8,
  parameter int LANES      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        pop,
  input  logic [FIFO_WIDTH-1:0]       data_in,
  input  logic                        out_ready,
  output logic                        lane_last,
  output logic [LANES*FIFO_WIDTH-1:0] out_data,
  output logic                        out_valid
);

  localparam int LW = $clog2(LANES);
  localparam int AW = (LANES - 1) * FIFO_WIDTH;

  logic [LW-1:0]               lane_cnt_q, lane_cnt_d;
  logic [AW-1:0]               asm_q, asm_d;
  logic [LANES*FIFO_WIDTH-1:0] out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;

  assign lane_last = (lane_cnt_q == LW'(LANES - 1));
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  // Next-state: lane fill, row completion, and valid/ready hold of the output.
  always_comb begin
    lane_cnt_d  = lane_cnt_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (clr) lane_cnt_d = '0;
    if (pop) begin
      if (lane_last) begin
        // Only reachable when the output slot is free or being accepted now.
        out_data_d  = {data_in, asm_q};
        out_valid_d = 1'b1;
        lane_cnt_d  = '0;
      end else begin
        for (int i = 0; i < LANES - 1; i++) begin
          if (lane_cnt_q == LW'(i)) asm_d[i*FIFO_WIDTH +: FIFO_WIDTH] = data_in;
        end
        lane_cnt_d = lane_cnt_q + LW'(1);
      end
    end
  end

  // Register update with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt_q  <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      lane_cnt_q  <= lane_cnt_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: rtl/fifo_row_reader.sv
// Read-side FIFO controller: pops words, packs LANES of them per row and
// streams num_rows rows per start pulse, then pulses done.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | popping words and emitting rows
//   DRAIN | all words popped, waiting for the last row to be accepted
module fifo_row_reader
  import tpu_pkg::*;
#(
  parameter int FIFO_WIDTH    = 8,
  parameter int LANES         = 4,
  parameter int ROW_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ROW_CNT_WIDTH-1:0] num_rows,
  fifo_row_reader_if.master        bus,
  output logic                     busy,
  output logic                     done
);

  row_reader_state_t        state_q, state_d;
  logic [ROW_CNT_WIDTH-1:0] rows_left_q, rows_left_d;
  logic                     done_q, done_d;
  logic                     clr;
  logic                     pop;
  logic                     stall;
  logic                     row_done;
  logic                     lane_last;
  logic                     out_valid;

  // Hold off the row-completing pop while the previous row is still unaccepted.
  assign stall    = lane_last && out_valid && !bus.out_ready;
  assign pop      = (state_q == RUN) && !bus.fifo_empty && !stall;
  assign row_done = pop && lane_last;

  assign bus.fifo_next_en = pop;
  assign bus.out_valid    = out_valid;
  assign busy             = (state_q == RUN) || (state_q == DRAIN);
  assign done             = done_q;

  row_assembler #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .LANES      (LANES)
  ) u_row_assembler (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .pop       (pop),
    .data_in   (bus.fifo_data_in),
    .out_ready (bus.out_ready),
    .lane_last (lane_last),
    .out_data  (bus.out_data),
    .out_valid (out_valid)
  );

  // Burst sequencing: row countdown and done generation.
  always_comb begin
    state_d     = state_q;
    rows_left_d = rows_left_q;
    done_d      = 1'b0;
    clr         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clr = 1'b1;
          if (num_rows != '0) begin
            state_d     = RUN;
            rows_left_d = num_rows;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (row_done) begin
          rows_left_d = rows_left_q - ROW_CNT_WIDTH'(1);
          if (rows_left_q == ROW_CNT_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid && bus.out_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM registers with asynchronous clear; reset aborts any burst silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rows_left_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_left_q <= rows_left_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_row_reader.sv
// Self-checking bench for fifo_row_reader: FIFO model plus row scoreboard.
module tb_fifo_row_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num_rows;
  logic        busy;
  logic        done;

  fifo_row_reader_if #(.FIFO_WIDTH(8), .LANES(4)) bus ();

  fifo_row_reader #(
    .FIFO_WIDTH    (8),
    .LANES         (4),
    .ROW_CNT_WIDTH (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_rows (num_rows),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  fifo_q[$];
  logic [31:0] exp_q[$];

  logic        s_pop, s_valid, s_done, s_busy;
  logic [31:0] s_data;
  int          n_pops, n_rows, n_done;

  task automatic refresh();
    bus.fifo_empty   = (fifo_q.size() == 0);
    bus.fifo_data_in = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  task automatic clear_all();
    fifo_q.delete();
    exp_q.delete();
    refresh();
    n_pops = 0;
    n_rows = 0;
    n_done = 0;
  endtask

  // One clock: sample at negedge+1, model the FIFO pop and score accepted rows.
  task automatic cycle();
    logic [31:0] exp_row;
    #1;
    s_pop   = bus.fifo_next_en;
    s_valid = bus.out_valid;
    s_data  = bus.out_data;
    s_done  = done;
    s_busy  = busy;
    if (s_pop) begin
      n_pops++;
      total++;
      if (fifo_q.size() == 0) begin
        bad++;
        $display("FAIL pop_when_empty: fifo_next_en=1 required 0");
      end
    end
    if (s_valid && bus.out_ready) begin
      n_rows++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_row: got %h required none", s_data);
      end else begin
        exp_row = exp_q.pop_front();
        if (s_data !== exp_row) begin
          bad++;
          $display("FAIL row_data: got %h required %h", s_data, exp_row);
        end
      end
    end
    if (s_done) n_done++;
    @(posedge clk);
    #1;
    if (s_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    refresh();
    @(negedge clk);
  endtask

  task automatic run_until_done(input int max, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max; i++) begin
      cycle();
      if (s_done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic pulse_start(input logic [15:0] n);
    start    = 1'b1;
    num_rows = n;
    cycle();
    start    = 1'b0;
    num_rows = 16'd0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        bus.fifo_next_en !== 1'b0 || bus.out_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b next_en=%b data=%h required 0",
               bus.out_valid, busy, done, bus.fifo_next_en, bus.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int first_valid;
    int done_k;
    clear_all();
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    bus.out_ready = 1'b1;
    first_valid = -1;
    done_k = -1;
    pulse_start(16'd2);
    for (int k = 1; k < 40; k++) begin
      cycle();
      if (k == 1) begin
        total++;
        if (s_busy !== 1'b1) begin
          bad++;
          $display("FAIL basic_busy: got %b required 1", s_busy);
        end
      end
      if (s_valid && first_valid < 0) first_valid = k;
      if (s_done) begin
        done_k = k;
        break;
      end
    end
    total++;
    if (first_valid != 5) begin
      bad++;
      $display("FAIL basic_latency: got %0d required 5", first_valid);
    end
    total++;
    if (done_k != 10) begin
      bad++;
      $display("FAIL basic_done_cycle: got %0d required 10", done_k);
    end
    total++;
    if (n_pops != 8 || n_rows != 2) begin
      bad++;
      $display("FAIL basic_counts: pops=%0d rows=%0d required 8 2", n_pops, n_rows);
    end
    cycle();
    total++;
    if (s_done !== 1'b0 || s_busy !== 1'b0 || s_pop !== 1'b0) begin
      bad++;
      $display("FAIL basic_after_done: done=%b busy=%b pop=%b required 0 0 0", s_done, s_busy, s_pop);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    bit seen;
    clear_all();
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    bus.out_ready = 1'b0;
    pulse_start(16'd2);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (s_valid) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL bp_first_valid: got timeout required out_valid");
    end
    for (int k = 0; k < 10; k++) begin
      cycle();
      total++;
      if (s_valid !== 1'b1 || s_data !== 32'h04030201) begin
        bad++;
        $display("FAIL bp_hold: valid=%b data=%h required 1 04030201", s_valid, s_data);
      end
    end
    total++;
    if (n_pops != 7) begin
      bad++;
      $display("FAIL bp_pops_stalled: got %0d required 7", n_pops);
    end
    bus.out_ready = 1'b1;
    run_until_done(40, to);
    total++;
    if (to || n_pops != 8 || n_rows != 2) begin
      bad++;
      $display("FAIL bp_finish: timeout=%b pops=%0d rows=%0d required 0 8 2", to, n_pops, n_rows);
    end
  endtask

  task automatic test_fifo_gap();
    bit to;
    clear_all();
    push_word(8'h11);
    push_word(8'h22);
    exp_q.push_back(32'h44332211);
    bus.out_ready = 1'b1;
    pulse_start(16'd1);
    cycle();
    cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      total++;
      if (s_pop !== 1'b0 || s_valid !== 1'b0 || s_busy !== 1'b1) begin
        bad++;
        $display("FAIL gap_idle: pop=%b valid=%b busy=%b required 0 0 1", s_pop, s_valid, s_busy);
      end
    end
    push_word(8'h33);
    push_word(8'h44);
    run_until_done(20, to);
    total++;
    if (to || n_pops != 4 || n_rows != 1) begin
      bad++;
      $display("FAIL gap_finish: timeout=%b pops=%0d rows=%0d required 0 4 1", to, n_pops, n_rows);
    end
  endtask

  task automatic test_zero_rows();
    clear_all();
    for (int i = 0; i < 4; i++) push_word(8'hE0 + 8'(i));
    bus.out_ready = 1'b1;
    pulse_start(16'd0);
    cycle();
    total++;
    if (s_done !== 1'b1 || s_busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_done: done=%b busy=%b required 1 0", s_done, s_busy);
    end
    cycle();
    total++;
    if (s_done !== 1'b0 || n_pops != 0 || n_done != 1) begin
      bad++;
      $display("FAIL zero_after: done=%b pops=%0d pulses=%0d required 0 0 1", s_done, n_pops, n_done);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_all();
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    exp_q.push_back(32'h04030201);
    bus.out_ready = 1'b0;
    pulse_start(16'd2);
    for (int k = 0; k < 6; k++) cycle();
    #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.fifo_next_en !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_precondition: valid=%b next_en=%b busy=%b required 1 1 1",
               bus.out_valid, bus.fifo_next_en, busy);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.fifo_next_en !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: valid=%b busy=%b next_en=%b done=%b required 0 0 0 0",
               bus.out_valid, busy, bus.fifo_next_en, done);
    end
    exp_q.delete();
    n_done = 0;
    @(negedge clk);
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    total++;
    if (n_done != 0) begin
      bad++;
      $display("FAIL rst_no_done: got %0d pulses required 0", n_done);
    end
    clear_all();
    for (int i = 1; i <= 4; i++) push_word(8'hA0 + 8'(i));
    exp_q.push_back(32'hA4A3A2A1);
    bus.out_ready = 1'b1;
    pulse_start(16'd1);
    run_until_done(20, to);
    total++;
    if (to || n_rows != 1 || n_pops != 4) begin
      bad++;
      $display("FAIL rst_restart: timeout=%b rows=%0d pops=%0d required 0 1 4", to, n_rows, n_pops);
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    clear_all();
    for (int i = 1; i <= 8; i++) push_word(8'h30 + 8'(i));
    exp_q.push_back(32'h34333231);
    bus.out_ready = 1'b1;
    pulse_start(16'd1);
    cycle();
    pulse_start(16'd5);
    run_until_done(30, to);
    cycle();
    cycle();
    total++;
    if (to || n_pops != 4 || n_rows != 1 || fifo_q.size() != 4) begin
      bad++;
      $display("FAIL start_ignored: timeout=%b pops=%0d rows=%0d left=%0d required 0 4 1 4",
               to, n_pops, n_rows, fifo_q.size());
    end
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    num_rows      = 16'd0;
    bus.out_ready = 1'b0;
    clear_all();
    test_reset();
    test_basic();
    test_backpressure();
    test_fifo_gap();
    test_zero_rows();
    test_reset_mid();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
